image_read_arbiter: RTL and testbench

- Shares the single read port of the image frame memory between NUM_REQ burst requesters, for example a pixel classifier and a host readout path.
- Grants requesters round-robin, then issues one burst of consecutive reads per grant at one address per cycle.
- Returns the read data tagged to the granted requester.
- Blocks new grants while the capture path is writing the frame, and flags any capture that overlaps an active burst.

---
 rtl/image_arb_pkg.sv | 21 ++
 rtl/image_read_arbiter_if.sv | 33 +++
 rtl/image_read_arbiter_rr_arbiter.sv | 49 ++++
 rtl/image_read_arbiter.sv | 136 +++++++++++++
 tb/tb_image_read_arbiter.sv | 335 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/image_arb_pkg.sv
// Shared types and default geometry for the image memory read arbiter.
// The capture side imports the same constants so both agree on the frame memory shape.
package image_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } arb_state_e;

  localparam int DEF_NUM_REQ  = 2;
  localparam int DEF_ADDR_W   = 16;
  localparam int DEF_DATA_W   = 12;
  localparam int DEF_MEM_SIZE = 3840;
  localparam int DEF_LEN_W    = 6;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/image_read_arbiter_if.sv
// Requester and memory-port bundle of the image read arbiter.
// The master side is the requesters plus the memory; the slave side is the arbiter.
interface image_read_arbiter_if
  import image_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int LEN_W   = DEF_LEN_W
);

  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] reqAddr;
  logic [NUM_REQ*LEN_W-1:0]  reqLen;
  logic [NUM_REQ-1:0]        ack;
  logic [NUM_REQ-1:0]        rdValid;
  logic                      rdLast;
  logic [DATA_W-1:0]         rdData;
  logic                      memReadEnable;
  logic [ADDR_W-1:0]         memReadAddr;
  logic [DATA_W-1:0]         memReadData;

  modport master (
    output req, reqAddr, reqLen, memReadData,
    input  ack, rdValid, rdLast, rdData, memReadEnable, memReadAddr
  );

  modport slave (
    input  req, reqAddr, reqLen, memReadData,
    output ack, rdValid, rdLast, rdData, memReadEnable, memReadAddr
  );

endinterface

// File: rtl/image_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first requester at or after the pointer wins,
// searching cyclically.
module rr_arbiter
  import image_arb_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               any_grant
);

  localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W+1)'(NUM_REQ);

  logic [2*NUM_REQ-1:0] dbl_s;
  logic [NUM_REQ-1:0]   rot_s;
  logic [PTR_W:0]       sum_s;

  // Rotate the requests so the pointer lands on bit 0, then take the lowest set bit.
  always_comb begin
    dbl_s     = {req, req};
    rot_s     = dbl_s[ptr +: NUM_REQ];
    any_grant = 1'b0;
    sum_s     = '0;
    grant     = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (rot_s[k]) begin
        any_grant = 1'b1;
        sum_s     = {1'b0, ptr} + (PTR_W+1)'(k);
      end else begin
        sum_s = sum_s;
      end
    end
    if (sum_s >= NUM_REQ_W) begin
      grant_idx = PTR_W'(sum_s - NUM_REQ_W);
    end else begin
      grant_idx = sum_s[PTR_W-1:0];
    end
    if (any_grant) begin
      grant[grant_idx] = 1'b1;
    end else begin
      grant = '0;
    end
  end

endmodule

// File: rtl/image_read_arbiter.sv
// Shares the image frame memory read port between burst requesters: round-robin grant,
// one address per cycle per burst, data steered back to the granted requester.
module image_read_arbiter
  import image_arb_pkg::*;
#(
  parameter int NUM_REQ  = DEF_NUM_REQ,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MEM_SIZE = DEF_MEM_SIZE,
  parameter int LEN_W    = DEF_LEN_W
) (
  input  logic                clock,
  input  logic                reset,
  image_read_arbiter_if.slave bus,
  input  logic                captureBusy,
  output logic                busy,
  output logic                error
);

  localparam int PTR_W = ptr_width(NUM_REQ);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_SIZE - 1);
  localparam logic [PTR_W-1:0]  LAST_PTR  = PTR_W'(NUM_REQ - 1);

  arb_state_e          state_r, state_s;
  logic [PTR_W-1:0]    ptr_r, ptr_s;
  logic [PTR_W-1:0]    gidx_r, gidx_s;
  logic [PTR_W-1:0]    win_idx_s;
  logic [NUM_REQ-1:0]  win_s;
  logic                win_any_s;
  logic [NUM_REQ-1:0]  ack_r, ack_s;
  logic [NUM_REQ-1:0]  rdv_r, rdv_s;
  logic [LEN_W-1:0]    cnt_r, cnt_s;
  logic [ADDR_W-1:0]   addr_r, addr_s;
  logic                mre_r, mre_s;
  logic                last_r, last_s;
  logic                busy_r, busy_s;
  logic                error_r, error_s;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr (
    .req       (bus.req),
    .ptr       (ptr_r),
    .grant     (win_s),
    .grant_idx (win_idx_s),
    .any_grant (win_any_s)
  );

  // Next-state and next-output decode; every output comes straight from a register.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    gidx_s  = gidx_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    mre_s   = mre_r;
    ack_s   = '0;
    rdv_s   = '0;
    rdv_s[gidx_r] = mre_r;
    // The beat whose address went out with the counter at zero is the burst's last.
    last_s  = mre_r && (cnt_r == '0);
    error_s = error_r | (captureBusy && (state_r != IDLE));
    case (state_r)
      IDLE: begin
        if (win_any_s && !captureBusy) begin
          state_s = BURST;
          ack_s   = win_s;
          mre_s   = 1'b1;
          addr_s  = bus.reqAddr[win_idx_s*ADDR_W +: ADDR_W];
          cnt_s   = bus.reqLen[win_idx_s*LEN_W +: LEN_W];
          ptr_s   = (win_idx_s == LAST_PTR) ? '0 : win_idx_s + 1'b1;
          gidx_s  = win_idx_s;
        end else begin
          mre_s = 1'b0;
        end
      end
      BURST: begin
        if (cnt_r == '0) begin
          mre_s   = 1'b0;
          state_s = DRAIN;
        end else begin
          addr_s = (addr_r == LAST_ADDR) ? '0 : addr_r + 1'b1;
          cnt_s  = cnt_r - 1'b1;
        end
      end
      DRAIN: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        mre_s   = 1'b0;
      end
    endcase
    busy_s = (state_s != IDLE);
  end

  // State and output registers; reset abandons any burst in flight.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      ptr_r   <= '0;
      gidx_r  <= '0;
      cnt_r   <= '0;
      addr_r  <= '0;
      mre_r   <= 1'b0;
      ack_r   <= '0;
      rdv_r   <= '0;
      last_r  <= 1'b0;
      busy_r  <= 1'b0;
      error_r <= 1'b0;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      gidx_r  <= gidx_s;
      cnt_r   <= cnt_s;
      addr_r  <= addr_s;
      mre_r   <= mre_s;
      ack_r   <= ack_s;
      rdv_r   <= rdv_s;
      last_r  <= last_s;
      busy_r  <= busy_s;
      error_r <= error_s;
    end
  end

  assign bus.ack           = ack_r;
  assign bus.rdValid       = rdv_r;
  assign bus.rdLast        = last_r;
  assign bus.rdData        = bus.memReadData;
  assign bus.memReadEnable = mre_r;
  assign bus.memReadAddr   = addr_r;
  assign busy              = busy_r;
  assign error             = error_r;

endmodule

// File: tb/tb_image_read_arbiter.sv
// Self-checking bench for image_read_arbiter: directed burst table, multi-cycle corner
// sequences, then randomized traffic against a transaction-level reference model.
module tb_image_read_arbiter;

  localparam int NR = 2;
  localparam int AW = 16;
  localparam int DW = 12;
  localparam int LW = 6;
  localparam int MS = 3840;

  typedef struct {
    int rq;
    int addr;
    int len;
    int exp_last_addr;
    int exp_beats;
  } vec_t;

  typedef struct {
    int   rq;
    int   addr;
    logic last;
  } beat_t;

  logic clock = 1'b0;
  logic reset;
  logic capture_busy;
  logic busy;
  logic error;

  image_read_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .LEN_W(LW)) bus ();

  image_read_arbiter #(
    .NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .MEM_SIZE(MS), .LEN_W(LW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .bus         (bus),
    .captureBusy (capture_busy),
    .busy        (busy),
    .error       (error)
  );

  logic [DW-1:0] mem [0:MS-1];
  int checks = 0;
  int failures = 0;

  vec_t  vecs [5];
  int    model_ptr, since_last, w, idx, ea, beats, lasts, n_ack, prev_c, last_idx;
  logic  in_burst, granted_this, issuing;
  logic [NR-1:0] snap, exp_ack;
  int    cd [NR];
  int    r_addr [NR];
  int    r_len [NR];
  beat_t bt;
  int    aq [$];
  beat_t bq [$];

  always #5 clock = ~clock;

  // Frame memory read port: data appears one cycle after the address.
  always @(posedge clock or posedge reset) begin
    if (reset) bus.memReadData <= '0;
    else if (bus.memReadEnable) bus.memReadData <= mem[bus.memReadAddr];
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int rq, input int addr, input int len, input logic val);
    bus.req[rq] = val;
    bus.reqAddr[rq*AW +: AW] = AW'(addr);
    bus.reqLen[rq*LW +: LW] = LW'(len);
  endtask

  task automatic wait_idle(input string name);
    for (int c = 0; c < 200; c++) begin
      if (!busy) break;
      @(negedge clock);
    end
    chk(name, busy, 0);
  endtask

  // One isolated burst from IDLE, checked beat by beat.
  task automatic run_burst(input int rq, input int addr, input int len,
                           input int exp_last, input int exp_beats);
    int nb, last_addr, done_c;
    set_req(rq, addr, len, 1'b1);
    @(negedge clock);
    chk("burst_ack", bus.ack, 64'(1 << rq));
    chk("burst_mre", bus.memReadEnable, 1);
    chk("burst_first_addr", bus.memReadAddr, 64'(addr));
    chk("burst_busy", busy, 1);
    set_req(rq, addr, len, 1'b0);
    nb = 0;
    last_addr = int'(bus.memReadAddr);
    done_c = -1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clock);
      if (bus.ack != '0) chk("burst_extra_ack", bus.ack, 0);
      if (bus.memReadEnable) begin
        chk("burst_addr", bus.memReadAddr, 64'((addr + nb + 1) % MS));
        last_addr = int'(bus.memReadAddr);
      end
      if (bus.rdValid != '0) begin
        chk("burst_dest", bus.rdValid, 64'(1 << rq));
        chk("burst_data", bus.rdData, mem[(addr + nb) % MS]);
        chk("burst_last", bus.rdLast, (nb == len));
        nb++;
      end
      if (!busy) begin
        done_c = c;
        break;
      end
    end
    chk("burst_beats", nb, exp_beats);
    chk("burst_final_addr", last_addr, exp_last);
    chk("burst_done_cycle", done_c, len + 1);
  endtask

  initial begin
    vecs[0] = '{0, 100, 3, 103, 4};
    vecs[1] = '{1, 3838, 3, 1, 4};
    vecs[2] = '{0, 0, 0, 0, 1};
    vecs[3] = '{1, 3800, 63, 23, 64};
    vecs[4] = '{1, 3839, 1, 0, 2};

    for (int i = 0; i < MS; i++) mem[i] = DW'($urandom);
    reset = 1'b1;
    capture_busy = 1'b0;
    bus.req = '0;
    bus.reqAddr = '0;
    bus.reqLen = '0;
    repeat (3) @(negedge clock);
    chk("reset_ack", bus.ack, 0);
    chk("reset_rdvalid", bus.rdValid, 0);
    chk("reset_rdlast", bus.rdLast, 0);
    chk("reset_mre", bus.memReadEnable, 0);
    chk("reset_addr", bus.memReadAddr, 0);
    chk("reset_busy", busy, 0);
    chk("reset_error", error, 0);
    reset = 1'b0;
    @(negedge clock);

    for (int v = 0; v < 5; v++) begin
      run_burst(vecs[v].rq, vecs[v].addr, vecs[v].len, vecs[v].exp_last_addr, vecs[v].exp_beats);
      @(negedge clock);
    end

    // Fairness: both requesters held high with single-beat bursts.
    set_req(0, 10, 0, 1'b1);
    set_req(1, 20, 0, 1'b1);
    n_ack = 0; prev_c = 0; last_idx = 0; beats = 0;
    for (int c = 0; c < 40 && n_ack < 6; c++) begin
      @(negedge clock);
      if (bus.rdValid != '0) begin
        beats++;
        chk("fair_beat_dest", bus.rdValid, 64'(1 << last_idx));
        chk("fair_beat_data", bus.rdData, mem[last_idx == 0 ? 10 : 20]);
      end
      if (bus.ack != '0) begin
        idx = bus.ack[1] ? 1 : 0;
        chk("fair_order", idx, n_ack % 2);
        if (n_ack > 0) chk("fair_spacing", c - prev_c, 3);
        prev_c = c; last_idx = idx; n_ack++;
      end
    end
    set_req(0, 10, 0, 1'b0);
    set_req(1, 20, 0, 1'b0);
    chk("fair_acks", n_ack, 6);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (bus.rdValid != '0) beats++;
      if (!busy) break;
    end
    chk("fair_beats", beats, 6);

    // Capture interlock while idle.
    capture_busy = 1'b1;
    set_req(1, 200, 2, 1'b1);
    n_ack = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clock);
      if (bus.ack != '0 || bus.memReadEnable) n_ack++;
    end
    chk("interlock_quiet", n_ack, 0);
    capture_busy = 1'b0;
    @(negedge clock);
    chk("interlock_grant", bus.ack, 2'b10);
    set_req(1, 200, 2, 1'b0);
    @(negedge clock);
    wait_idle("interlock_idle");
    chk("interlock_error", error, 0);

    // Capture overlapping an 8-beat burst.
    set_req(0, 500, 7, 1'b1);
    @(negedge clock);
    chk("conf_ack", bus.ack, 1);
    set_req(0, 500, 7, 1'b0);
    beats = 0; lasts = 0;
    for (int c = 0; c < 40; c++) begin
      if (c == 2) capture_busy = 1'b1;
      if (c == 4) capture_busy = 1'b0;
      @(negedge clock);
      if (c == 0) chk("conf_error_before", error, 0);
      if (bus.rdValid != '0) begin
        chk("conf_data", bus.rdData, mem[500 + beats]);
        beats++;
        if (bus.rdLast) lasts++;
      end
      if (!busy) break;
    end
    chk("conf_beats", beats, 8);
    chk("conf_lasts", lasts, 1);
    chk("conf_error", error, 1);
    repeat (10) @(negedge clock);
    chk("conf_error_sticky", error, 1);

    // Asynchronous reset in the middle of a burst.
    set_req(0, 700, 7, 1'b1);
    @(negedge clock);
    chk("rst_ack", bus.ack, 1);
    set_req(0, 700, 7, 1'b0);
    repeat (3) @(negedge clock);
    chk("rst_beat_active", bus.rdValid, 1);
    #2 reset = 1'b1;
    #1;
    chk("rst_mre", bus.memReadEnable, 0);
    chk("rst_rdvalid", bus.rdValid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_error", error, 0);
    @(negedge clock);
    reset = 1'b0;
    set_req(0, 40, 0, 1'b1);
    set_req(1, 60, 0, 1'b1);
    @(negedge clock);
    chk("rst_ptr_grant", bus.ack, 2'b01);
    set_req(0, 40, 0, 1'b0);
    set_req(1, 60, 0, 1'b0);
    @(negedge clock);
    wait_idle("rst_idle");

    // Randomized traffic against the transaction-level model.
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    model_ptr = 0; since_last = 2; in_burst = 1'b0; snap = '0;
    for (int i = 0; i < NR; i++) begin
      cd[i] = 0; r_addr[i] = 0; r_len[i] = 0;
    end
    for (int cyc = 0; cyc < 3200; cyc++) begin
      @(negedge clock);
      issuing = (cyc < 2700);
      since_last++;
      exp_ack = '0;
      w = -1;
      if (!in_burst && since_last >= 2 && snap != '0) begin
        for (int k = 0; k < NR; k++) begin
          idx = (model_ptr + k) % NR;
          if (w < 0 && snap[idx]) w = idx;
        end
        exp_ack[w] = 1'b1;
      end
      if (bus.ack != '0 || exp_ack != '0) chk("rand_ack", bus.ack, exp_ack);
      granted_this = (w >= 0);
      if (w >= 0) begin
        model_ptr = (w + 1) % NR;
        in_burst = 1'b1;
        for (int b = 0; b <= r_len[w]; b++) begin
          aq.push_back((r_addr[w] + b) % MS);
          bt.rq = w;
          bt.addr = (r_addr[w] + b) % MS;
          bt.last = (b == r_len[w]);
          bq.push_back(bt);
        end
      end
      if (bus.memReadEnable || aq.size() != 0) begin
        if (aq.size() == 0) begin
          chk("rand_mre", bus.memReadEnable, 0);
        end else begin
          ea = aq.pop_front();
          chk("rand_mre", bus.memReadEnable, 1);
          chk("rand_addr", bus.memReadAddr, 64'(ea));
        end
      end
      if (bus.rdValid != '0 || (bq.size() != 0 && !granted_this)) begin
        if (bq.size() == 0 || granted_this) begin
          chk("rand_rdvalid", bus.rdValid, 0);
        end else begin
          bt = bq.pop_front();
          chk("rand_dest", bus.rdValid, 64'(1 << bt.rq));
          chk("rand_data", bus.rdData, mem[bt.addr]);
          chk("rand_last", bus.rdLast, bt.last);
          if (bt.last) begin
            in_burst = 1'b0;
            since_last = 0;
          end
        end
      end
      for (int i = 0; i < NR; i++) begin
        if (bus.req[i] && bus.ack[i]) begin
          if (!(issuing && $urandom_range(0, 3) == 0)) begin
            bus.req[i] = 1'b0;
            cd[i] = int'($urandom_range(0, 6));
          end
        end else if (!bus.req[i]) begin
          if (cd[i] > 0) begin
            cd[i]--;
          end else if (issuing) begin
            r_addr[i] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(MS - 8, MS - 1))
                                                    : int'($urandom_range(0, MS - 1));
            r_len[i]  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 63))
                                                    : int'($urandom_range(0, 7));
            set_req(i, r_addr[i], r_len[i], 1'b1);
          end
        end
      end
      snap = bus.req;
    end
    chk("rand_addr_drained", aq.size(), 0);
    chk("rand_beats_drained", bq.size(), 0);
    chk("rand_all_acked", bus.req, 0);
    chk("rand_busy_end", busy, 0);
    chk("rand_error", error, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
